imm_ext_arbiter: RTL and testbench

Shares one immediate-extension unit between two requesters, the decode stage (port 0) and the branch-target unit (port 1). Arbitration is round-robin, with a valid/ready handshake on each request port. Each granted request is extended to 32 bits according to a 2-bit mode. The result enters a 2-entry response FIFO that is drained through a single valid/ready response port, tagged with the requester ID. The block sits between decode and the ALU/branch-address path.

---
 rtl/imm_ext_pkg.sv | 23 ++
 rtl/imm_ext_unit.sv | 34 +++
 rtl/imm_ext_arbiter.sv | 115 +++++++++++
 tb/tb_imm_ext_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate-extension arbiter.
// Extension modes, FIFO occupancy states and width defaults.
package imm_ext_pkg;

  localparam int DEF_IMM_W  = 15;
  localparam int DEF_DATA_W = 32;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    SEXT      = 2'd0,
    ZEXT      = 2'd1,
    SEXT_SHL2 = 2'd2,
    UPPER     = 2'd3
  } ext_mode_t;

  // Encoded so the state value equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_st_t;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational immediate extender: i_imm, i_mode -> o_data.
// Ports: i_imm (IMM_W), i_mode (ext_mode_t), o_data (DATA_W).
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int IMM_W  = DEF_IMM_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [IMM_W-1:0]  i_imm,
  input  ext_mode_t         i_mode,
  output logic [DATA_W-1:0] o_data
);

  localparam int PAD_W = DATA_W - IMM_W;

  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_upper;

  assign w_sext  = {{PAD_W{i_imm[IMM_W-1]}}, i_imm};
  assign w_zext  = {{PAD_W{1'b0}}, i_imm};
  assign w_upper = {i_imm, {PAD_W{1'b0}}};

  always_comb begin
    o_data = w_sext;
    unique case (i_mode)
      SEXT:      o_data = w_sext;
      ZEXT:      o_data = w_zext;
      SEXT_SHL2: o_data = w_sext << 2;
      UPPER:     o_data = w_upper;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one extender between two requesters,
// feeding a 2-entry tagged response FIFO with valid/ready ports.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int IMM_W  = DEF_IMM_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [IMM_W-1:0]  req_imm0,
  input  logic [IMM_W-1:0]  req_imm1,
  input  logic [1:0]        req_mode0,
  input  logic [1:0]        req_mode1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_id
);

  fifo_st_t          r_state;
  logic              r_rr_ptr;
  logic              r_head;
  logic              r_tail;
  logic [DATA_W-1:0] r_data [FIFO_DEPTH];
  logic              r_id   [FIFO_DEPTH];

  logic              w_pop;
  logic              w_push;
  logic              w_space;
  logic              w_ok;
  logic              w_sel;
  logic [1:0]        w_grant;
  logic [IMM_W-1:0]  w_imm;
  ext_mode_t         w_mode;
  logic [DATA_W-1:0] w_ext;

  assign resp_valid = (r_state != EMPTY);
  assign resp_data  = r_data[r_head];
  assign resp_id    = r_id[r_head];

  assign w_pop   = resp_valid & resp_ready;
  // A pop frees the head slot in the same edge, so full+pop still has room.
  assign w_space = (r_state != FULL) | w_pop;
  // Grants are blocked while reset is asserted.
  assign w_ok    = w_space & rst_n;

  always_comb begin
    w_grant = 2'b00;
    unique case (1'b1)
      w_ok && (req_valid == 2'b11):
        w_grant = r_rr_ptr ? 2'b10 : 2'b01;
      w_ok && (req_valid == 2'b01):
        w_grant = 2'b01;
      w_ok && (req_valid == 2'b10):
        w_grant = 2'b10;
      default:
        w_grant = 2'b00;
    endcase
  end

  assign req_ready = w_grant;
  assign w_push    = |w_grant;
  assign w_sel     = w_grant[1];
  assign w_imm     = w_sel ? req_imm1 : req_imm0;
  assign w_mode    = ext_mode_t'(w_sel ? req_mode1 : req_mode0);

  imm_ext_unit #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_ext (
    .i_imm  (w_imm),
    .i_mode (w_mode),
    .o_data (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_rr_ptr <= 1'b0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_id[i]   <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_data[r_tail] <= w_ext;
        r_id[r_tail]   <= w_sel;
        r_tail         <= ~r_tail;
        r_rr_ptr       <= ~w_sel;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      unique case (r_state)
        EMPTY: begin
          if (w_push) r_state <= ONE;
        end
        ONE: begin
          if (w_push && !w_pop) r_state <= FULL;
          else if (!w_push && w_pop) r_state <= EMPTY;
        end
        FULL: begin
          if (w_pop && !w_push) r_state <= ONE;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed self-checking bench for imm_ext_arbiter.
// Covers reset, modes, fairness, backpressure, full push/pop, reset.
module tb_imm_ext_arbiter;
  import imm_ext_pkg::*;

  localparam int IW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [IW-1:0] req_imm0;
  logic [IW-1:0] req_imm1;
  logic [1:0]    req_mode0;
  logic [1:0]    req_mode1;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_ext_arbiter #(
    .IMM_W  (IW),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_imm0   (req_imm0),
    .req_imm1   (req_imm1),
    .req_mode0  (req_mode0),
    .req_mode1  (req_mode1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 1'b0;
    req_imm0   = '0;
    req_imm1   = '0;
    req_mode0  = 2'd0;
    req_mode1  = 2'd0;
    step();
    step();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %0b want 0", resp_valid);
    end
    n_checks++;
    if (resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_data: got %h want 0", resp_data);
    end
    n_checks++;
    if (resp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_id: got %0b want 0", resp_id);
    end
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 00", req_ready);
    end
    req_valid = 2'b00;
    rst_n     = 1'b1;
    step();
  endtask

  task automatic test_modes();
    logic [IW-1:0] m_imm [4];
    logic [1:0]    m_mode [4];
    logic [DW-1:0] m_exp [4];
    m_imm  = '{15'h4000, 15'h4000, 15'h7FFF, 15'h0001};
    m_mode = '{2'd0, 2'd1, 2'd2, 2'd3};
    m_exp  = '{32'hFFFFC000, 32'h00004000,
               32'hFFFFFFFC, 32'h00020000};
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_imm0  = m_imm[i];
      req_mode0 = m_mode[i];
      req_valid = 2'b01;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
        n_fail++;
        $display("FAIL mode%0d_ready: got %b want 01",
                 i, req_ready);
      end
      n_checks++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mode%0d_bypass: got %0b want 0",
                 i, resp_valid);
      end
      step();
      req_valid = 2'b00;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_data !== m_exp[i]
          || resp_id !== 1'b0) begin
        n_fail++;
        $display("FAIL mode%0d_data: got v%0b %h id%0b want v1 %h id0",
                 i, resp_valid, resp_data, resp_id, m_exp[i]);
      end
      step();
      n_checks++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mode%0d_drain: got %0b want 0",
                 i, resp_valid);
      end
    end
  endtask

  task automatic test_fairness();
    logic [1:0]    exp_rdy;
    logic          exp_id;
    logic [DW-1:0] exp_d;
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    req_imm0   = 15'h00AA;
    req_imm1   = 15'h0055;
    req_mode0  = 2'd1;
    req_mode1  = 2'd1;
    resp_ready = 1'b1;
    req_valid  = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_id  = k[0];
      exp_rdy = exp_id ? 2'b10 : 2'b01;
      exp_d   = exp_id ? 32'h55 : 32'hAA;
      n_checks++;
      if (req_ready !== exp_rdy || !$onehot(req_ready)) begin
        n_fail++;
        $display("FAIL fair%0d_ready: got %b want %b",
                 k, req_ready, exp_rdy);
      end
      step();
      n_checks++;
      if (resp_valid !== 1'b1 || resp_id !== exp_id
          || resp_data !== exp_d) begin
        n_fail++;
        $display("FAIL fair%0d_resp: got v%0b id%0b %h want v1 id%0b %h",
                 k, resp_valid, resp_id, resp_data, exp_id, exp_d);
      end
    end
    req_valid = 2'b00;
    step();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fair_drain: got %0b want 0", resp_valid);
    end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    req_mode1  = 2'd1;
    req_imm1   = 15'h0001;
    req_valid  = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_acc1: got %b want 10", req_ready);
    end
    step();
    req_imm1 = 15'h0002;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_acc2: got %b want 10", req_ready);
    end
    step();
    req_imm1 = 15'h0003;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_full: got %b want 00", req_ready);
    end
    step();
    n_checks++;
    if (req_ready !== 2'b00 || resp_valid !== 1'b1
        || resp_data !== 32'h1 || resp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got r%b v%0b %h id%0b want r00 v1 1 id1",
               req_ready, resp_valid, resp_data, resp_id);
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_pushpop: got %b want 10", req_ready);
    end
    step();
    req_valid = 2'b00;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h2) begin
      n_fail++;
      $display("FAIL bp_drain2: got v%0b %h want v1 2",
               resp_valid, resp_data);
    end
    step();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h3) begin
      n_fail++;
      $display("FAIL bp_drain3: got v%0b %h want v1 3",
               resp_valid, resp_data);
    end
    step();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: got %0b want 0", resp_valid);
    end
  endtask

  task automatic test_full_push_pop();
    resp_ready = 1'b0;
    req_mode0  = 2'd1;
    req_imm0   = 15'h0010;
    req_valid  = 2'b01;
    #1;
    step();
    req_imm0 = 15'h0011;
    step();
    req_imm0 = 15'h0012;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL fpp_full: got %b want 00", req_ready);
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01 || resp_data !== 32'h10) begin
      n_fail++;
      $display("FAIL fpp_same: got r%b %h want r01 10",
               req_ready, resp_data);
    end
    step();
    resp_ready = 1'b0;
    req_imm0   = 15'h0013;
    #1;
    n_checks++;
    if (req_ready !== 2'b00 || resp_data !== 32'h11) begin
      n_fail++;
      $display("FAIL fpp_still_full: got r%b %h want r00 11",
               req_ready, resp_data);
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    step();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h12) begin
      n_fail++;
      $display("FAIL fpp_order: got v%0b %h want v1 12",
               resp_valid, resp_data);
    end
    step();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_empty: got %0b want 0", resp_valid);
    end
  endtask

  task automatic test_reset_midstream();
    resp_ready = 1'b0;
    req_mode1  = 2'd1;
    req_imm1   = 15'h0005;
    req_valid  = 2'b10;
    #1;
    step();
    req_imm1 = 15'h0006;
    step();
    req_imm0  = 15'h00AA;
    req_mode0 = 2'd1;
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 2'b00
        || resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mrst_now: got v%0b r%b %h want v0 r00 0",
               resp_valid, req_ready, resp_data);
    end
    step();
    n_checks++;
    if (req_ready !== 2'b00 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_held: got r%b v%0b want r00 v0",
               req_ready, resp_valid);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL mrst_prio: got %b want 01", req_ready);
    end
    step();
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0
        || resp_data !== 32'hAA) begin
      n_fail++;
      $display("FAIL mrst_first: got v%0b id%0b %h want v1 id0 aa",
               resp_valid, resp_id, resp_data);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_modes();
    test_fairness();
    test_backpressure();
    test_full_push_pop();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
